mike_cacheline_adaptor: RTL and testbench
=========================================

Name: mike_cacheline_adaptor

Overview:
- Memory-side responder for the cache's pmem interface.
- Accepts one 256-bit line read or write request from the cache controller (pmem_read/pmem_write style).
- Performs it as a 4-beat, 64-bit burst transaction on physical memory, then returns a single-cycle completion pulse to the cache.
- Sits between the L1 cache datapath/controller and the burst memory model.

Parameters:
- LINE_W, 256, cache line width in bits.
- BURST_W, 64, memory beat width in bits. BEATS = LINE_W/BURST_W = 4.
- ADDR_W, 32, address width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- line_i  input  LINE_W  write line from cache (pmem_wdata)
- line_o  output  LINE_W  assembled read line to cache (pmem_rdata)
- address_i  input  ADDR_W  line address from cache
- read_i  input  1  cache line read request (pmem_read)
- write_i  input  1  cache line write request (pmem_write)
- resp_o  output  1  line transaction complete (pmem_resp)
- burst_i  input  BURST_W  read beat from memory
- burst_o  output  BURST_W  write beat to memory
- address_o  output  ADDR_W  burst address to memory
- read_o  output  1  memory burst read request
- write_o  output  1  memory burst write request
- resp_i  input  1  memory beat valid/accepted

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: state IDLE, beat counter 0, line_o 0, burst_o 0, address_o 0, read_o/write_o/resp_o 0, write buffer 0.
- Reset mid-burst: same reset values from the next edge; the partial line is discarded and no resp_o is issued.
- States: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
- IDLE:
  - Outputs inactive.
  - read_i=1: latch address_o = {address_i[ADDR_W-1:5], 5'b0}, cnt=0, go RD_BURST.
  - Else write_i=1: also latch line_i into the write buffer, go WR_BURST.
  - read_i and write_i both 1: read wins.
  - resp_i is ignored.
- RD_BURST:
  - read_o=1, address_o held.
  - Each cycle with resp_i=1: line_o[BURST_W*cnt +: BURST_W] <= burst_i, cnt++.
  - resp_i=0 is a stall: no capture, cnt unchanged, gaps are allowed.
  - On the beat with cnt==BEATS-1, go RD_DONE with cnt wrapping to 0. read_o drops on that edge.
- RD_DONE: resp_o=1 for exactly one cycle, line_o fully valid and stable, then IDLE.
- WR_BURST:
  - write_o=1, burst_o = buffer[BURST_W*cnt +: BURST_W], combinationally tracking cnt.
  - resp_i=1 accepts the beat: cnt++.
  - After the last beat, go WR_DONE.
- WR_DONE: resp_o=1 for one cycle, then IDLE.
- Latency with zero-wait memory (resp_i high every cycle):
  - Request sampled at edge 0.
  - read_o/write_o high during cycles 1-4.
  - resp_o high in cycle 5.
  - Back in IDLE at cycle 6.
- Once a burst starts, read_i/write_i changes are ignored until IDLE; the burst always completes.
- line_o holds its value until the next read burst overwrites it. Write bursts never modify line_o.
- The cache deasserts its request the cycle after resp_o. IDLE re-samples requests, so back-to-back write-then-read (dirty eviction then fill) needs no idle gap beyond the IDLE cycle.
- resp_o never asserts in the same cycle as read_o or write_o.

Test Plan:
- Read, zero-wait: address_i=0x0000_1234, read_i=1; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x0000_1220; read_o high 4 cycles; resp_o one pulse in cycle 5; line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write with stalls: line_i = {D3,D2,D1,D0}, write_i=1; resp_i pattern 1,0,0,1,1,0,1 -> burst_o presents D0, D1 (held through the stall), D1, D1, D2, D3, D3 in order; write_o high 7 cycles; single resp_o pulse afterwards; line_o unchanged.
- Dirty eviction sequence: write burst to 0x0000_0040 completes (resp_o), then the cache raises read_i at 0x0000_0080 -> read burst starts from IDLE with address_o=0x0000_0080; no spurious second resp_o.
- Simultaneous read_i=1, write_i=1 in IDLE -> read burst only; write_o stays 0.
- Reset after 2 read beats -> next cycle: state IDLE, read_o=0, resp_o=0, line_o=0. A new read then completes with cnt starting from 0.
- Request dropped mid-burst (read_i=0 after beat 1) -> burst still completes 4 beats and pulses resp_o once.

Source files
------------

// File: rtl/mike_cacheline_adaptor_if.sv
// Cache-side and memory-side signals of the cacheline adaptor.
// The adaptor uses the slave view. The cache/memory environment uses the master view.
interface mike_cacheline_adaptor_if #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int ADDR_W  = 32
);
   logic [LINE_W-1:0]  line_i;
   logic [LINE_W-1:0]  line_o;
   logic [ADDR_W-1:0]  address_i;
   logic               read_i;
   logic               write_i;
   logic               resp_o;
   logic [BURST_W-1:0] burst_i;
   logic [BURST_W-1:0] burst_o;
   logic [ADDR_W-1:0]  address_o;
   logic               read_o;
   logic               write_o;
   logic               resp_i;

   modport slave (
      input  line_i, address_i, read_i, write_i, burst_i, resp_i,
      output line_o, resp_o, burst_o, address_o, read_o, write_o
   );

   modport master (
      output line_i, address_i, read_i, write_i, burst_i, resp_i,
      input  line_o, resp_o, burst_o, address_o, read_o, write_o
   );
endinterface

// File: rtl/mike_cacheline_adaptor.sv
// Converts one cache line read/write into a 4-beat memory burst.
// It returns a single-cycle completion pulse to the cache.
module mike_cacheline_adaptor #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int ADDR_W  = 32
) (
   input logic                      clk,
   input logic                      rst,
   mike_cacheline_adaptor_if.slave  bus
);
   localparam int BEATS = LINE_W / BURST_W;
   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0]  LAST     = CNT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);

   typedef enum logic [2:0] {IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [LINE_W-1:0]  line_q;
   logic [LINE_W-1:0]  wbuf;
   logic [ADDR_W-1:0]  addr_q;
   logic               rd_q;
   logic               wr_q;
   logic               resp_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         line_q <= '0;
         wbuf   <= '0;
         addr_q <= '0;
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
         resp_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               // Read wins when both requests are raised together
               if (bus.read_i) begin
                  addr_q <= bus.address_i & ~OFF_MASK;
                  cnt    <= '0;
                  rd_q   <= 1'b1;
                  state  <= RD_BURST;
               end else if (bus.write_i) begin
                  addr_q <= bus.address_i & ~OFF_MASK;
                  wbuf   <= bus.line_i;
                  cnt    <= '0;
                  wr_q   <= 1'b1;
                  state  <= WR_BURST;
               end
            end
            RD_BURST: begin
               if (bus.resp_i) begin
                  line_q[BURST_W*cnt +: BURST_W] <= bus.burst_i;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST) begin
                     rd_q   <= 1'b0;
                     resp_q <= 1'b1;
                     state  <= RD_DONE;
                  end
               end
            end
            WR_BURST: begin
               if (bus.resp_i) begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST) begin
                     wr_q   <= 1'b0;
                     resp_q <= 1'b1;
                     state  <= WR_DONE;
                  end
               end
            end
            RD_DONE, WR_DONE: begin
               resp_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Write beat follows cnt directly so a stalled beat stays on the bus
   assign bus.burst_o   = (state == WR_BURST) ? wbuf[BURST_W*cnt +: BURST_W] : '0;
   assign bus.line_o    = line_q;
   assign bus.address_o = addr_q;
   assign bus.read_o    = rd_q;
   assign bus.write_o   = wr_q;
   assign bus.resp_o    = resp_q;
endmodule

// File: tb/tb_mike_cacheline_adaptor.sv
// Self-checking bench for mike_cacheline_adaptor: a vector table, hand sequences and random bursts.
// The bench plays both the cache and the memory, and it keeps its own model of line_o.
module tb_mike_cacheline_adaptor;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mike_cacheline_adaptor_if bus ();

   mike_cacheline_adaptor dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [255:0] model_line = '0;

   typedef struct {
      bit           rd;
      bit           wr;
      logic [31:0]  addr;
      logic [255:0] data;
      int           stall_pct;
      logic [31:0]  exp_addr;
      int           exp_cycles;
   } vec_t;

   vec_t vecs [6];

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [255:0] rand256();
      return {rand64(), rand64(), rand64(), rand64()};
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete line transaction.
   // A nonzero plen forces an explicit resp_i pattern.
   task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] exp_addr, input logic [255:0] data,
                          input int stall_pct, input logic [15:0] pat, input int plen,
                          input int exp_cycles);
      bit is_rd;
      bit r;
      int beat;
      int cyc;
      is_rd = rd;
      beat  = 0;
      cyc   = 0;
      bus.read_i    = rd;
      bus.write_i   = wr;
      bus.address_i = addr;
      bus.line_i    = is_rd ? rand256() : data;
      bus.resp_i    = 1'($urandom % 2);
      bus.burst_i   = rand64();
      step();
      while (beat < 4 && cyc < 200) begin
         check("read_o_burst", 256'(bus.read_o), 256'(is_rd));
         check("write_o_burst", 256'(bus.write_o), 256'(!is_rd));
         check("resp_o_burst", 256'(bus.resp_o), 256'(0));
         check("address_o", 256'(bus.address_o), 256'(exp_addr));
         if (!is_rd) check("burst_o", 256'(bus.burst_o), 256'(data[64*beat +: 64]));
         r = (plen > 0) ? pat[cyc % 16] : ($urandom_range(99) >= stall_pct);
         bus.resp_i  = r;
         bus.burst_i = (r && is_rd) ? data[64*beat +: 64] : rand64();
         bus.read_i  = 1'($urandom % 2);
         bus.write_i = 1'($urandom % 2);
         bus.line_i  = rand256();
         if (r) beat++;
         cyc++;
         step();
      end
      if (beat < 4) begin
         n_cmp++;
         n_err++;
         $display("[TB] FAIL burst_timeout: got %0d beats required 4", beat);
         rst = 1'b1;
         step();
         rst = 1'b0;
         model_line = '0;
         return;
      end
      if (is_rd) model_line = data;
      if (exp_cycles > 0) check("burst_cycles", 256'(cyc), 256'(exp_cycles));
      bus.read_i  = 1'b0;
      bus.write_i = 1'b0;
      bus.resp_i  = 1'($urandom % 2);
      check("resp_o_done", 256'(bus.resp_o), 256'(1));
      check("read_o_done", 256'(bus.read_o), 256'(0));
      check("write_o_done", 256'(bus.write_o), 256'(0));
      check("line_o_done", bus.line_o, model_line);
      step();
      check("resp_o_idle", 256'(bus.resp_o), 256'(0));
      check("busy_idle", 256'({bus.read_o, bus.write_o}), 256'(0));
      check("line_o_idle", bus.line_o, model_line);
   endtask

   initial begin
      logic [31:0]  a;
      logic [255:0] d;
      bit           rd;
      bit           wr;

      vecs[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1234,
                  data: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                  stall_pct: 0, exp_addr: 32'h0000_1220, exp_cycles: 4};
      vecs[1] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_0040,
                  data: {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                         64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000},
                  stall_pct: 0, exp_addr: 32'h0000_0040, exp_cycles: 4};
      vecs[2] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0080,
                  data: {64'hCAFE_F00D_0000_0004, 64'hCAFE_F00D_0000_0003,
                         64'hCAFE_F00D_0000_0002, 64'hCAFE_F00D_0000_0001},
                  stall_pct: 0, exp_addr: 32'h0000_0080, exp_cycles: 4};
      vecs[3] = '{rd: 1'b1, wr: 1'b1, addr: 32'hFFFF_FFFF,
                  data: {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                         64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_F0F0_0F0F_F0F0},
                  stall_pct: 0, exp_addr: 32'hFFFF_FFE0, exp_cycles: 4};
      vecs[4] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_001F,
                  data: {64'h8888_0000_0000_0008, 64'h7777_0000_0000_0007,
                         64'h6666_0000_0000_0006, 64'h5555_0000_0000_0005},
                  stall_pct: 40, exp_addr: 32'h0000_0000, exp_cycles: -1};
      vecs[5] = '{rd: 1'b1, wr: 1'b0, addr: 32'hABCD_EF7F,
                  data: {64'hBEEF_0000_0000_0004, 64'hBEEF_0000_0000_0003,
                         64'hBEEF_0000_0000_0002, 64'hBEEF_0000_0000_0001},
                  stall_pct: 40, exp_addr: 32'hABCD_EF60, exp_cycles: -1};

      bus.read_i    = 1'b0;
      bus.write_i   = 1'b0;
      bus.address_i = '0;
      bus.line_i    = '0;
      bus.burst_i   = '0;
      bus.resp_i    = 1'b0;
      rst = 1'b1;
      step();
      step();
      check("rst_line_o", bus.line_o, 256'(0));
      check("rst_address_o", 256'(bus.address_o), 256'(0));
      check("rst_burst_o", 256'(bus.burst_o), 256'(0));
      check("rst_ctrl", 256'({bus.read_o, bus.write_o, bus.resp_o}), 256'(0));
      rst = 1'b0;
      step();
      check("idle_ctrl", 256'({bus.read_o, bus.write_o, bus.resp_o}), 256'(0));

      for (int i = 0; i < 6; i++)
         run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].exp_addr, vecs[i].data,
                 vecs[i].stall_pct, 16'h0, 0, vecs[i].exp_cycles);

      // Stalled write with resp_i = 1,0,0,1,1,0,1. The line_o value must survive.
      run_txn(1'b0, 1'b1, 32'h0000_0300, 32'h0000_0300,
              {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
               64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0},
              0, 16'h0059, 7, 7);

      // Reset after two read beats.
      bus.read_i    = 1'b1;
      bus.address_i = 32'h0000_2000;
      step();
      for (int b = 0; b < 2; b++) begin
         bus.read_i  = 1'b0;
         bus.resp_i  = 1'b1;
         bus.burst_i = rand64();
         step();
      end
      rst = 1'b1;
      step();
      model_line = '0;
      check("midrst_line_o", bus.line_o, model_line);
      check("midrst_ctrl", 256'({bus.read_o, bus.write_o, bus.resp_o}), 256'(0));
      check("midrst_address_o", 256'(bus.address_o), 256'(0));
      rst = 1'b0;
      bus.resp_i = 1'b0;
      step();
      check("postrst_resp_o", 256'(bus.resp_o), 256'(0));
      run_txn(1'b1, 1'b0, 32'h0000_2004, 32'h0000_2000,
              {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
               64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001},
              0, 16'h0, 0, 4);

      for (int i = 0; i < 40; i++) begin
         rd = 1'($urandom % 2);
         wr = rd ? 1'($urandom % 2) : 1'b1;
         a  = $urandom;
         d  = rand256();
         run_txn(rd, wr, a, a - (a % 32), d, $urandom_range(60), 16'h0, 0, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
